// File: rtl/ether_tx_arbiter.sv
// ether_tx_arbiter: round-robin share of the ether_tx_driver write port.
// Captures one frame from the winning requester, holds it on the driver
// valid/ready port, then waits IFG_CYCLES idle cycles before the next grant.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_data/req_ready : NUM_REQ frame sources, ready is a capture pulse
//   tx_drv_wr_data/valid/ready   : registered frame port to ether_tx_driver
//   grant_id                     : requester whose frame is held or last sent
//   busy                         : high whenever the FSM is not IDLE
// Optional (ETHER_TX_ARB_STATS_EN): stat_clr, stat_frames per-requester counters.
module ether_tx_arbiter #(
   parameter int NUM_REQ            = 2,
   parameter int ETH_MAX_FRAME_SIZE = 256,
   parameter int IFG_CYCLES         = 12,
   parameter int STAT_WIDTH         = 16,
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_REQ-1:0]                    req_valid,
   input  logic [NUM_REQ*ETH_MAX_FRAME_SIZE-1:0] req_data,
   output logic [NUM_REQ-1:0]                    req_ready,
   output logic [ETH_MAX_FRAME_SIZE-1:0]         tx_drv_wr_data,
   output logic                                  tx_drv_wr_valid,
   input  logic                                  tx_drv_wr_ready,
   output logic [IDW-1:0]                        grant_id,
   output logic                                  busy
`ifdef ETHER_TX_ARB_STATS_EN
   ,
   input  logic                                  stat_clr,
   output logic [NUM_REQ*STAT_WIDTH-1:0]         stat_frames
`endif
);

   localparam int W  = ETH_MAX_FRAME_SIZE;
   localparam int CW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
   localparam logic [CW-1:0] IFG_LD = CW'(IFG_CYCLES);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] ptr_nxt;
   logic [IDW-1:0] sel;
   logic           found;
   logic [CW-1:0]  gap_cnt;
   logic           capture;
   logic           accept;

   // Two passes give the wrap-around search: first requesters at or above
   // the pointer, then the ones below it.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
            found = 1'b1;
            sel   = IDW'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i]) begin
            found = 1'b1;
            sel   = IDW'(i);
         end
      end
   end

   always_comb begin
      ptr_nxt = '0;
      if (int'(sel) != NUM_REQ - 1)
         ptr_nxt = sel + 1'b1;
   end

   assign capture = (state == IDLE) && found;
   assign accept  = (state == SEND) && tx_drv_wr_ready;
   assign busy    = (state != IDLE);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (found) state_nxt = SEND;
         SEND: begin
            if (tx_drv_wr_ready)
               state_nxt = (IFG_CYCLES == 0) ? IDLE : GAP;
         end
         GAP:  if (gap_cnt <= CW'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr          <= '0;
         gap_cnt         <= '0;
         tx_drv_wr_data  <= '0;
         tx_drv_wr_valid <= 1'b0;
         req_ready       <= '0;
         grant_id        <= '0;
      end else begin
         req_ready <= '0;
         if (capture) begin
            tx_drv_wr_data  <= req_data[int'(sel)*W +: W];
            tx_drv_wr_valid <= 1'b1;
            grant_id        <= sel;
            req_ready       <= NUM_REQ'(1) << sel;
            rr_ptr          <= ptr_nxt;
         end
         if (accept) begin
            tx_drv_wr_valid <= 1'b0;
            gap_cnt         <= IFG_LD;
         end else if (state == GAP) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

`ifdef ETHER_TX_ARB_STATS_EN
   logic [STAT_WIDTH-1:0] stat_cnt [NUM_REQ];

   // Clear has priority over a same-cycle accept; counters stick at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
      end else if (stat_clr) begin
         for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && (int'(grant_id) == i) && (stat_cnt[i] != '1))
               stat_cnt[i] <= stat_cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      stat_frames = '0;
      for (int i = 0; i < NUM_REQ; i++)
         stat_frames[i*STAT_WIDTH +: STAT_WIDTH] = stat_cnt[i];
   end
`endif

endmodule

// File: tb/tb_ether_tx_arbiter.sv
// Bench for ether_tx_arbiter: directed steps, scoreboard of sent frames.
// Second instance runs with IFG_CYCLES=0 and a 2-bit stat width.
module tb_ether_tx_arbiter;

   localparam int W = 256;

   typedef struct packed {
      logic [0:0]   id;
      logic [W-1:0] data;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;

   logic [1:0]     req_valid = '0;
   logic [2*W-1:0] req_data = '0;
   logic [1:0]     req_ready;
   logic [W-1:0]   wr_data;
   logic           wr_valid;
   logic           wr_ready = 1'b1;
   logic [0:0]     grant_id;
   logic           busy;

   logic [1:0]     req_valid1 = '0;
   logic [2*W-1:0] req_data1 = '0;
   logic [1:0]     req_ready1;
   logic [W-1:0]   wr_data1;
   logic           wr_valid1;
   logic           wr_ready1 = 1'b1;
   logic [0:0]     grant_id1;
   logic           busy1;

`ifdef ETHER_TX_ARB_STATS_EN
   logic           stat_clr = 1'b0;
   logic [31:0]    stat_frames;
   logic           stat_clr1 = 1'b0;
   logic [3:0]     stat_frames1;
`endif

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   ether_tx_arbiter #(
      .NUM_REQ(2), .ETH_MAX_FRAME_SIZE(W), .IFG_CYCLES(12), .STAT_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .tx_drv_wr_data(wr_data), .tx_drv_wr_valid(wr_valid),
      .tx_drv_wr_ready(wr_ready), .grant_id(grant_id), .busy(busy)
`ifdef ETHER_TX_ARB_STATS_EN
      , .stat_clr(stat_clr), .stat_frames(stat_frames)
`endif
   );

   ether_tx_arbiter #(
      .NUM_REQ(2), .ETH_MAX_FRAME_SIZE(W), .IFG_CYCLES(0), .STAT_WIDTH(2)
   ) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid1), .req_data(req_data1), .req_ready(req_ready1),
      .tx_drv_wr_data(wr_data1), .tx_drv_wr_valid(wr_valid1),
      .tx_drv_wr_ready(wr_ready1), .grant_id(grant_id1), .busy(busy1)
`ifdef ETHER_TX_ARB_STATS_EN
      , .stat_clr(stat_clr1), .stat_frames(stat_frames1)
`endif
   );

   function automatic logic [W-1:0] frame(input int n);
      return {8{32'hF00D0000 | 32'(n)}};
   endfunction

   task automatic check(input string tag,
                        input logic [W-1:0] obs,
                        input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every driver accept pops the oldest expected frame.
   always @(negedge clk) begin
      if (rst && wr_valid && wr_ready) begin
         n_cmp++;
         assert (exp_q.size() != 0) else begin
            n_bad++;
            $error("FAIL sb_empty: observed accept expected none");
         end
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_id", W'(grant_id), W'(e.id));
            check("sb_data", wr_data, e.data);
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rr(output int waited);
      waited = 0;
      do begin
         step;
         waited++;
      end while (req_ready == 2'b00 && waited < 60);
   endtask

   task automatic wait_rr1(output int waited);
      waited = 0;
      do begin
         step;
         waited++;
      end while (req_ready1 == 2'b00 && waited < 60);
   endtask

   task automatic wait_idle;
      int g;
      g = 0;
      while (busy && g < 60) begin
         step;
         g++;
      end
      check("idle_reached", W'(busy), W'(0));
   endtask

   task automatic do_reset;
      req_valid  = '0;
      req_valid1 = '0;
      #2 rst = 1'b0;
      step;
      #2 rst = 1'b1;
      step;
   endtask

`ifdef ETHER_TX_ARB_STATS_EN
   task automatic send_one(input int id, input logic [W-1:0] f);
      int w;
      req_data[id*W +: W] = f;
      req_valid[id] = 1'b1;
      exp_q.push_back({1'(id), f});
      wait_rr(w);
      req_valid = '0;
      wait_idle;
   endtask
`endif

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int w;
      int g;
      int bcnt;
      int last;
      int cnt;
      logic stable;
      logic saw;
      logic [1:0] oh;
      logic [W-1:0] f;

      // Reset values
      #1 rst = 1'b0;
      #1;
      check("rst_valid", W'(wr_valid), W'(0));
      check("rst_data", wr_data, '0);
      check("rst_ready", W'(req_ready), W'(0));
      check("rst_grant", W'(grant_id), W'(0));
      check("rst_busy", W'(busy), W'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      step;

      // Single request from requester 0
      req_data[W-1:0] = frame(0);
      req_valid = 2'b01;
      exp_q.push_back({1'b0, frame(0)});
      step;
      check("t1_ready", W'(req_ready), W'(2'b01));
      check("t1_valid", W'(wr_valid), W'(1));
      check("t1_data", wr_data, frame(0));
      check("t1_grant", W'(grant_id), W'(0));
      req_valid = 2'b00;
      step;
      check("t1_ready_pulse", W'(req_ready), W'(0));
      check("t1_valid_pulse", W'(wr_valid), W'(0));
      bcnt = 1;
      g = 0;
      while (busy && g < 40) begin
         bcnt++;
         g++;
         step;
      end
      check("t1_busy_cycles", W'(bcnt), W'(13));

      // Both requesting: order 0,1,0,1 with 14-cycle spacing
      do_reset;
      req_data = {frame(1), frame(0)};
      exp_q.push_back({1'b0, frame(0)});
      exp_q.push_back({1'b1, frame(1)});
      req_valid = 2'b11;
      last = 0;
      for (int k = 0; k < 4; k++) begin
         wait_rr(w);
         oh = 2'b01 << (k % 2);
         check($sformatf("t2_ready%0d", k), W'(req_ready), W'(oh));
         check($sformatf("t2_grant%0d", k), W'(grant_id), W'(k % 2));
         if (k > 0)
            check($sformatf("t2_space%0d", k), W'(cyc - last), W'(14));
         last = cyc;
         if (k < 2) begin
            f = frame(k + 2);
            req_data[(k % 2)*W +: W] = f;
            exp_q.push_back({1'(k % 2), f});
         end else begin
            req_valid[k % 2] = 1'b0;
         end
      end
      wait_idle;

      // Backpressure for 20 cycles; late request waits out the gap
      wr_ready = 1'b0;
      req_data[W-1:0] = frame(10);
      req_valid = 2'b01;
      exp_q.push_back({1'b0, frame(10)});
      wait_rr(w);
      check("t3_cap", W'(req_ready), W'(2'b01));
      req_valid = 2'b00;
      stable = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step;
         if (!(wr_valid === 1'b1 && wr_data === frame(10))) stable = 1'b0;
         if (req_ready != 2'b00) saw = 1'b1;
         if (i == 4) begin
            req_data[2*W-1:W] = frame(11);
            req_valid = 2'b10;
            exp_q.push_back({1'b1, frame(11)});
         end
      end
      check("t3_stable", W'(stable), W'(1));
      check("t3_no_grant", W'(saw), W'(0));
      wr_ready = 1'b1;
      wait_rr(w);
      check("t3_wait", W'(w), W'(14));
      check("t3_ready1", W'(req_ready), W'(2'b10));
      req_valid = 2'b00;
      wait_idle;

      // IFG_CYCLES=0 instance: a frame every 2 cycles
      req_data1 = {frame(21), frame(20)};
      req_valid1 = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_rr1(w);
         oh = 2'b01 << (k % 2);
         check($sformatf("t4_ready%0d", k), W'(req_ready1), W'(oh));
         check($sformatf("t4_grant%0d", k), W'(grant_id1), W'(k % 2));
         check($sformatf("t4_data%0d", k), wr_data1, frame(20 + k));
         check($sformatf("t4_space%0d", k), W'(w), W'((k == 0) ? 1 : 2));
         if (k < 2) req_data1[(k % 2)*W +: W] = frame(k + 22);
         else       req_valid1[k % 2] = 1'b0;
      end
      step;

      // Asynchronous reset while a frame is held
      wr_ready = 1'b0;
      req_data[2*W-1:W] = frame(30);
      req_valid = 2'b10;
      wait_rr(w);
      check("t5_grant_pre", W'(grant_id), W'(1));
      check("t5_valid_pre", W'(wr_valid), W'(1));
      req_valid = 2'b00;
      #2 rst = 1'b0;
      #1;
      check("t5_valid_rst", W'(wr_valid), W'(0));
      check("t5_grant_rst", W'(grant_id), W'(0));
      check("t5_data_rst", wr_data, '0);
      check("t5_busy_rst", W'(busy), W'(0));
      @(posedge clk);
      #3 rst = 1'b1;
      req_data[2*W-1:W] = frame(31);
      req_valid = 2'b10;
      exp_q.push_back({1'b1, frame(31)});
      wr_ready = 1'b1;
      wait_rr(w);
      check("t5_ready_post", W'(req_ready), W'(2'b10));
      check("t5_grant_post", W'(grant_id), W'(1));
      req_valid = 2'b00;
      wait_idle;

`ifdef ETHER_TX_ARB_STATS_EN
      do_reset;
      send_one(0, frame(40));
      send_one(0, frame(41));
      send_one(0, frame(42));
      send_one(1, frame(43));
      check("st_counts", W'(stat_frames), W'({16'd1, 16'd3}));
      wr_ready = 1'b0;
      req_data[W-1:0] = frame(44);
      req_valid = 2'b01;
      exp_q.push_back({1'b0, frame(44)});
      wait_rr(w);
      req_valid = 2'b00;
      stat_clr = 1'b1;
      wr_ready = 1'b1;
      step;
      stat_clr = 1'b0;
      check("st_clr_wins", W'(stat_frames), W'(0));
      wait_idle;
      do_reset;
      req_valid1 = 2'b01;
      cnt = 0;
      g = 0;
      while (cnt < 5 && g < 60) begin
         step;
         g++;
         if (req_ready1[0]) cnt++;
      end
      req_valid1 = 2'b00;
      step;
      step;
      check("st_sat", W'(stat_frames1), W'({2'd0, 2'd3}));
`endif

      check("sb_drain", W'(exp_q.size()), W'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ether_tx_arbiter.md
Name: ether_tx_arbiter

Overview:
- Round-robin arbiter sharing the single ether_tx_driver write port between NUM_REQ frame sources (e.g. CPU frame buffer, ARP responder).
- Captures one whole frame from the winning requester into a holding register, then presents it on the driver's valid/ready write port.
- Enforces a programmable idle gap between successive frames handed to the driver.
- Sits between the frame producers and ether_tx_driver in the clk domain.

Parameters:
- NUM_REQ, 2, number of requesters (>=1).
- ETH_MAX_FRAME_SIZE, 256, frame vector width in bits; matches ether_tx_driver.
- IFG_CYCLES, 12, clk cycles spent in GAP after each accepted frame (0 allowed).
- STAT_WIDTH, 16, width of each per-requester frame counter (optional feature only).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester frame available.
- req_data  input  NUM_REQ*ETH_MAX_FRAME_SIZE  frames; requester i occupies bits [i*ETH_MAX_FRAME_SIZE +: ETH_MAX_FRAME_SIZE].
- req_ready  output  NUM_REQ  one-cycle capture pulse to the granted requester.
- tx_drv_wr_data  output  ETH_MAX_FRAME_SIZE  frame to driver, registered.
- tx_drv_wr_valid  output  1  frame valid to driver, registered.
- tx_drv_wr_ready  input  1  driver accepts frame.
- grant_id  output  max(1,$clog2(NUM_REQ))  index of the requester whose frame is held or last sent.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock/reset: one clock (clk); reset rst is asynchronous, active-low.
- Reset values: tx_drv_wr_valid=0, tx_drv_wr_data=0, req_ready=0, grant_id=0, busy=0, state=IDLE, rr_ptr=0, gap counter=0.
- Handshake: a transfer occurs on a cycle where valid and ready are both high. A requester holds req_valid and req_data stable until it sees req_ready.
- IDLE:
  - If any req_valid is high, select the first set bit searching from rr_ptr upward, with wrap-around modulo NUM_REQ.
  - On that clock edge: capture the selected frame into tx_drv_wr_data, set grant_id, pulse req_ready[sel] for exactly the next cycle, set tx_drv_wr_valid=1, set rr_ptr=(sel+1) mod NUM_REQ, go to SEND.
  - Latency: req_valid high in cycle t gives req_ready[sel] and tx_drv_wr_valid high in cycle t+1.
- SEND:
  - Hold tx_drv_wr_data and tx_drv_wr_valid=1 until tx_drv_wr_ready is high.
  - On the accepting edge: tx_drv_wr_valid=0, load gap counter with IFG_CYCLES, go to GAP. If IFG_CYCLES==0, go directly to IDLE.
  - tx_drv_wr_ready high on the first SEND cycle is accepted immediately, so tx_drv_wr_valid is high for exactly 1 cycle.
  - New requests are ignored in SEND.
- GAP:
  - Decrement the counter each cycle; when it reaches 1, go to IDLE on the next edge.
  - GAP therefore lasts exactly IFG_CYCLES cycles; no captures occur during GAP.
- Fairness: a requester holding req_valid continuously waits at most NUM_REQ-1 other frames.
- Request withdrawal: a requester may drop req_valid before it is granted, with no effect. Deasserting after its req_ready pulse has no effect on the held frame.
- tx_drv_wr_ready while not in SEND: ignored.
- NUM_REQ==1: same behaviour with a degenerate pointer; grant_id is 1 bit and is always 0.
- Reset mid-operation: any held frame is discarded and the block returns to reset values immediately (asynchronous). No req_ready pulse is produced.

Optional Feature:
- Macro: ETHER_TX_ARB_STATS_EN.
- Defined:
  - Adds input stat_clr (1 bit) and output stat_frames (NUM_REQ*STAT_WIDTH).
  - Counter i increments by 1 on each driver-accepted frame whose grant_id==i.
  - Counters saturate at all-ones.
  - stat_clr zeroes all counters synchronously; clear wins over a same-cycle increment.
  - Reset value of all counters is 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single request, NUM_REQ=2, IFG_CYCLES=12, tx_drv_wr_ready tied 1: req_valid=2'b01 with frame A at cycle 0.
  - req_ready=2'b01 and tx_drv_wr_valid=1 with data A in cycle 1 only.
  - busy high for 13 cycles, then IDLE.
- Simultaneous requests, req_valid=2'b11 held, ready=1: frames are sent in order 0,1,0,1.
  - Consecutive tx_drv_wr_valid pulses are spaced 14 cycles apart.
  - grant_id alternates 0,1.
- Backpressure: tx_drv_wr_ready=0 for 20 cycles after capture.
  - tx_drv_wr_valid and tx_drv_wr_data are stable for all 20 cycles.
  - A new req_valid on requester 1 gets no req_ready until after the GAP completes.
- IFG_CYCLES=0, both requesting, ready=1: frames are sent every 2 cycles (IDLE, SEND alternating).
- Reset mid-SEND: drive rst=0 asynchronously between edges.
  - tx_drv_wr_valid falls immediately; grant_id=0.
  - After release with req_valid=2'b10, requester 1 is granted first.
- With ETHER_TX_ARB_STATS_EN defined: send 3 frames from requester 0 and 1 frame from requester 1.
  - stat_frames reads {1,3}.
  - Asserting stat_clr in the same cycle as an accept gives {0,0}.
  - With STAT_WIDTH=2, 5 frames from requester 0 saturate its counter at 3.
